// File: rtl/bcg_fill_sequencer.sv
// Command-port scheduler in front of the BCG/VRAM decoder: arbitrates the CPU
// command stream against a 64x32 buffer-fill engine and owns the clear pointer.
module bcg_fill_sequencer #(
    parameter int unsigned MAX_STALL = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_start,
    input  logic [23:0] cpu_in,
    output logic        cpu_ready,
    input  logic        fill_req,
    input  logic        fill_mode,
    input  logic [7:0]  fill_value,
    output logic        fill_busy,
    output logic        fill_done,
    output logic        start,
    output logic [23:0] in,
    output logic [5:0]  clearx,
    output logic [4:0]  cleary
);
    typedef enum logic {ST_IDLE = 1'b0, ST_FILL = 1'b1} state_t;

    localparam logic [3:0]  MAX_STALL_C = 4'(MAX_STALL);
    localparam logic [10:0] PTR_LAST    = 11'h7FF;

    function automatic logic is_buf_op(input logic [7:0] opcode);
        is_buf_op = (opcode == 8'd244) || (opcode == 8'd252);
    endfunction

    function automatic logic [23:0] fill_cmd(input logic mode, input logic [7:0] value);
        if (mode) begin
            fill_cmd = {8'd244, 12'd0, value[3:0]};
        end else begin
            fill_cmd = {8'd252, 8'd0, value};
        end
    endfunction

    // Pointer kept as {py, px}: a plain 11-bit increment gives the row-major walk and the wrap.
    state_t      state_q, state_d;
    logic [10:0] ptr_q, ptr_d;
    logic [3:0]  stall_q, stall_d;
    logic        mode_q, mode_d;
    logic [7:0]  value_q, value_d;
    logic        start_q, start_d;
    logic [23:0] in_q, in_d;
    logic [10:0] clr_q, clr_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        cpu_grant_s;
    logic        fill_grant_s;

    assign cpu_ready    = !((state_q == ST_FILL) &&
                            ((stall_q == MAX_STALL_C) || is_buf_op(cpu_in[23:16])));
    assign cpu_grant_s  = cpu_start && cpu_ready;
    assign fill_grant_s = !cpu_grant_s && (state_q == ST_FILL);

    assign start     = start_q;
    assign in        = in_q;
    assign clearx    = clr_q[5:0];
    assign cleary    = clr_q[10:6];
    assign fill_done = done_q;
    assign fill_busy = busy_q;

    // Next-state: arbitration, pointer walk, stall accounting and fill start/finish.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        stall_d = stall_q;
        mode_d  = mode_q;
        value_d = value_q;
        start_d = 1'b0;
        in_d    = in_q;
        clr_d   = clr_q;
        done_d  = 1'b0;

        if (cpu_grant_s) begin
            start_d = 1'b1;
            in_d    = cpu_in;
            clr_d   = ptr_q;
            if (is_buf_op(cpu_in[23:16])) begin
                ptr_d = ptr_q + 11'd1;
            end else begin
                ptr_d = ptr_q;
            end
            if ((state_q == ST_FILL) && (stall_q < MAX_STALL_C)) begin
                stall_d = stall_q + 4'd1;
            end else begin
                stall_d = stall_q;
            end
        end else if (fill_grant_s) begin
            start_d = 1'b1;
            in_d    = fill_cmd(mode_q, value_q);
            clr_d   = ptr_q;
            ptr_d   = ptr_q + 11'd1;
            stall_d = 4'd0;
            if (ptr_q == PTR_LAST) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end else begin
                state_d = ST_FILL;
            end
        end else begin
            start_d = 1'b0;
        end

        // A new fill owns the pointer even if the CPU slipped a buffer op in this cycle.
        if ((state_q == ST_IDLE) && fill_req) begin
            mode_d  = fill_mode;
            value_d = fill_value;
            ptr_d   = 11'd0;
            stall_d = 4'd0;
            state_d = ST_FILL;
        end else begin
            mode_d  = mode_q;
            value_d = value_q;
        end

        busy_d = (state_d == ST_FILL);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 11'd0;
            stall_q <= 4'd0;
            mode_q  <= 1'b0;
            value_q <= 8'd0;
            start_q <= 1'b0;
            in_q    <= 24'd0;
            clr_q   <= 11'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            stall_q <= stall_d;
            mode_q  <= mode_d;
            value_q <= value_d;
            start_q <= start_d;
            in_q    <= in_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_bcg_fill_sequencer.sv
// Directed bench for bcg_fill_sequencer: fill walk, CPU pointer streaming,
// buffer-op stalling, forced fill slots and asynchronous abort.
module tb_bcg_fill_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_start;
    logic [23:0] cpu_in;
    logic        cpu_ready;
    logic        fill_req;
    logic        fill_mode;
    logic [7:0]  fill_value;
    logic        fill_busy;
    logic        fill_done;
    logic        start;
    logic [23:0] dut_in;
    logic [5:0]  clearx;
    logic [4:0]  cleary;

    int n_pass  = 0;
    int n_total = 0;

    bcg_fill_sequencer #(.MAX_STALL(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_start(cpu_start), .cpu_in(cpu_in), .cpu_ready(cpu_ready),
        .fill_req(fill_req), .fill_mode(fill_mode), .fill_value(fill_value),
        .fill_busy(fill_busy), .fill_done(fill_done),
        .start(start), .in(dut_in), .clearx(clearx), .cleary(cleary)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse fill_req for one IDLE cycle; returns in the first FILL cycle.
    task automatic start_fill(input logic mode, input logic [7:0] value);
        fill_mode  = mode;
        fill_value = value;
        fill_req   = 1'b1;
        tick();
        fill_req   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; cpu_start = 1'b0; cpu_in = 24'd0;
        fill_req = 1'b0; fill_mode = 1'b0; fill_value = 8'd0;
        #3;
        tick();
        rst = 1'b1;
        tick();
        n_total++;
        if ({start, dut_in, clearx, cleary} !== 36'd0) $display("FAIL reset_cmd: got start=%b in=%h x=%0d y=%0d expected all 0", start, dut_in, clearx, cleary);
        else n_pass++;
        n_total++;
        if ({fill_busy, fill_done} !== 2'b00) $display("FAIL reset_fill: got busy=%b done=%b expected 0 0", fill_busy, fill_done);
        else n_pass++;
        n_total++;
        if (cpu_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cpu_ready);
        else n_pass++;
    endtask

    task automatic test_fill_basic();
        int err = 0;
        start_fill(1'b0, 8'h5A);
        n_total++;
        if (start !== 1'b0 || fill_busy !== 1'b1) $display("FAIL fill_first_cycle: got start=%b busy=%b expected 0 1", start, fill_busy);
        else n_pass++;
        for (int k = 0; k < 2048; k++) begin
            tick();
            if (start !== 1'b1 || dut_in !== 24'hFC005A || clearx !== 6'(k % 64) ||
                cleary !== 5'(k / 64) || fill_done !== (k == 2047)) err++;
            if (k == 0 || k == 63 || k == 64 || k == 2047) begin
                n_total++;
                if (clearx !== 6'(k % 64) || cleary !== 5'(k / 64) || dut_in !== 24'hFC005A)
                    $display("FAIL fill_spot_%0d: got in=%h x=%0d y=%0d expected FC005A %0d %0d", k, dut_in, clearx, cleary, k % 64, k / 64);
                else n_pass++;
            end
        end
        n_total++;
        if (err !== 0) $display("FAIL fill_walk: got %0d bad cycles expected 0", err);
        else n_pass++;
        n_total++;
        if (fill_done !== 1'b1 || fill_busy !== 1'b0) $display("FAIL fill_end: got done=%b busy=%b expected 1 0", fill_done, fill_busy);
        else n_pass++;
        tick();
        n_total++;
        if (start !== 1'b0 || fill_done !== 1'b0) $display("FAIL fill_after: got start=%b done=%b expected 0 0", start, fill_done);
        else n_pass++;
    endtask

    task automatic test_cpu_stream();
        int err = 0;
        logic [5:0] exp_x [3] = '{6'd62, 6'd63, 6'd0};
        logic [4:0] exp_y [3] = '{5'd0, 5'd0, 5'd1};
        cpu_start = 1'b1;
        for (int j = 0; j < 65; j++) begin
            cpu_in = (j < 62) ? 24'hFC0000 | 24'(j) : 24'hF40000 | 24'(j);
            #1;
            if (cpu_ready !== 1'b1) err++;
            tick();
            if (start !== 1'b1 || dut_in !== cpu_in) err++;
            if (j >= 62) begin
                n_total++;
                if (clearx !== exp_x[j-62] || cleary !== exp_y[j-62])
                    $display("FAIL cpu_ptr_%0d: got x=%0d y=%0d expected %0d %0d", j - 62, clearx, cleary, exp_x[j-62], exp_y[j-62]);
                else n_pass++;
            end
        end
        cpu_start = 1'b0;
        n_total++;
        if (err !== 0) $display("FAIL cpu_stream: got %0d bad cycles expected 0", err);
        else n_pass++;
        tick();
    endtask

    task automatic test_buffer_op_stall();
        int err = 0;
        start_fill(1'b0, 8'h00);
        cpu_start = 1'b1;
        cpu_in    = 24'hFC0011;
        #1;
        for (int j = 0; j < 2048; j++) begin
            if (cpu_ready !== 1'b0) err++;
            tick();
            if (start !== 1'b1 || dut_in !== 24'hFC0000) err++;
        end
        n_total++;
        if (err !== 0) $display("FAIL bufop_stall: got %0d bad cycles expected 0", err);
        else n_pass++;
        n_total++;
        if (fill_busy !== 1'b0 || fill_done !== 1'b1 || cpu_ready !== 1'b1)
            $display("FAIL bufop_idle: got busy=%b done=%b ready=%b expected 0 1 1", fill_busy, fill_done, cpu_ready);
        else n_pass++;
        tick();
        n_total++;
        if (start !== 1'b1 || dut_in !== 24'hFC0011 || clearx !== 6'd0 || cleary !== 5'd0)
            $display("FAIL bufop_accept: got start=%b in=%h x=%0d y=%0d expected 1 FC0011 0 0", start, dut_in, clearx, cleary);
        else n_pass++;
        cpu_in = 24'h0D0000;
        tick();
        cpu_start = 1'b0;
        n_total++;
        if (dut_in !== 24'h0D0000 || clearx !== 6'd1 || cleary !== 5'd0)
            $display("FAIL bufop_ptr: got in=%h x=%0d y=%0d expected 0D0000 1 0", dut_in, clearx, cleary);
        else n_pass++;
        tick();
    endtask

    task automatic test_stall_limit();
        int pat_err = 0;
        int rdy_err = 0;
        int done_err = 0;
        logic [23:0] exp_in;
        start_fill(1'b1, 8'h07);
        cpu_start = 1'b1;
        cpu_in    = 24'h0D0000;
        #1;
        for (int j = 0; j <= 10240; j++) begin
            if (j > 0) begin
                exp_in = ((j - 1) % 5 == 4) ? 24'hF40007 : 24'h0D0000;
                if (start !== 1'b1 || dut_in !== exp_in) pat_err++;
                if (fill_done !== (j - 1 == 10239)) done_err++;
                if (j == 5) begin
                    n_total++;
                    if (dut_in !== 24'hF40007 || clearx !== 6'd0)
                        $display("FAIL stall_first_fill: got in=%h x=%0d expected F40007 0", dut_in, clearx);
                    else n_pass++;
                end
            end
            if (j < 10240) begin
                if (fill_busy !== 1'b1) done_err++;
                if (cpu_ready !== (j % 5 != 4)) rdy_err++;
                tick();
            end else begin
                cpu_start = 1'b0;
                n_total++;
                if (fill_busy !== 1'b0) $display("FAIL stall_busy_end: got %b expected 0", fill_busy);
                else n_pass++;
            end
        end
        n_total++;
        if (pat_err !== 0) $display("FAIL stall_pattern: got %0d bad cycles expected 0", pat_err);
        else n_pass++;
        n_total++;
        if (rdy_err !== 0) $display("FAIL stall_ready: got %0d bad cycles expected 0", rdy_err);
        else n_pass++;
        n_total++;
        if (done_err !== 0) $display("FAIL stall_done: got %0d bad cycles expected 0", done_err);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_fill();
        int pulses = 0;
        int bad = 0;
        logic seen_done = 1'b0;
        logic [10:0] first_ptr = 11'h7FF;
        start_fill(1'b0, 8'h33);
        for (int c = 0; c < 100; c++) tick();
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if ({start, dut_in, clearx, cleary, fill_busy, fill_done} !== 38'd0)
            $display("FAIL abort_async: got start=%b in=%h x=%0d y=%0d busy=%b done=%b expected all 0", start, dut_in, clearx, cleary, fill_busy, fill_done);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (fill_done !== 1'b0 || start !== 1'b0) bad++;
        end
        rst = 1'b1;
        tick();
        if (fill_done !== 1'b0 || start !== 1'b0 || fill_busy !== 1'b0) bad++;
        n_total++;
        if (bad !== 0) $display("FAIL abort_quiet: got %0d bad cycles expected 0", bad);
        else n_pass++;
        start_fill(1'b0, 8'h44);
        for (int c = 0; c < 2100; c++) begin
            tick();
            fill_req = (c == 500);
            if (start === 1'b1) begin
                pulses++;
                if (pulses == 1) first_ptr = {cleary, clearx};
            end
            if (fill_done === 1'b1) begin
                seen_done = 1'b1;
                break;
            end
        end
        fill_req = 1'b0;
        n_total++;
        if (seen_done !== 1'b1 || pulses != 2048)
            $display("FAIL refill_count: got done=%b pulses=%0d expected 1 2048", seen_done, pulses);
        else n_pass++;
        n_total++;
        if (first_ptr !== 11'd0) $display("FAIL refill_origin: got %h expected 000", first_ptr);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill_basic();
        test_cpu_stream();
        test_buffer_op_stall();
        test_stall_limit();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bcg_fill_sequencer.md
Name: bcg_fill_sequencer

Overview:
- Command-stream scheduler placed in front of the BCG/VRAM command decoder.
- Shares the decoder's single {start, in[23:0]} command port between the CPU command stream and an internal buffer-fill engine.
- Fill engine walks all 64x32 buffer positions, issuing LOAD BUFFER (252) or LOAD BUFFER PALETTE (244) commands with a constant value.
- Owns the clearx/cleary pointer consumed by the decoder, and auto-increments it for CPU-issued 244/252 commands so software can stream buffer data.

Parameters:
- MAX_STALL, 4: maximum consecutive cycles the fill engine may lose arbitration to the CPU before it is force-granted one slot (range 1..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- cpu_start  in  1  CPU command valid.
- cpu_in  in  24  CPU command; opcode in [23:16].
- cpu_ready  out  1  combinational; CPU command accepted on a cycle with cpu_start & cpu_ready.
- fill_req  in  1  start-fill pulse, sampled only in IDLE.
- fill_mode  in  1  0 = tile buffer (252), 1 = palette buffer (244).
- fill_value  in  8  fill data; mode 1 uses [3:0].
- fill_busy  out  1  high while in FILL.
- fill_done  out  1  one-cycle pulse on the last fill command.
- start  out  1  registered command strobe to the decoder.
- in  out  24  registered command to the decoder.
- clearx  out  6  registered buffer X pointer accompanying the command.
- cleary  out  5  registered buffer Y pointer accompanying the command.

Behaviour:
- Reset values: all outputs 0; state IDLE; pointer (px, py) = (0, 0); stall_cnt = 0; latched mode/value = 0. Reset mid-fill aborts with no fill_done pulse.
- Buffer op: a command whose opcode is 244 or 252.
- States:
  - IDLE: fill_req=1 latches fill_mode/fill_value, sets pointer to (0, 0), stall_cnt=0, next state FILL.
  - FILL: fill_busy=1; fill_req is ignored.
- cpu_ready = NOT (FILL AND (stall_cnt == MAX_STALL OR cpu_in is a buffer op)).
  - In IDLE, cpu_ready = 1.
- Grant each cycle:
  - CPU wins when cpu_start & cpu_ready.
  - Otherwise, in FILL, the fill engine wins.
  - Otherwise, no command.
- Output latency: one cycle. Outputs registered at the edge ending the grant cycle:
  - start = 1 if any grant, else 0.
  - in/clearx/cleary update only on a grant; otherwise they hold their previous values.
- CPU grant:
  - in <= cpu_in; clearx/cleary <= (px, py).
  - If a buffer op, pointer post-increments.
  - In FILL, stall_cnt increments, saturating at MAX_STALL.
- Fill grant:
  - in <= {8'd252, 8'd0, value} in mode 0, or {8'd244, 12'd0, value[3:0]} in mode 1.
  - clearx/cleary <= (px, py); pointer post-increments; stall_cnt <= 0.
- Pointer increment:
  - px+1 when px < 63.
  - px = 63 → px = 0, py+1.
  - (63, 31) → (0, 0).
- Fill completion: the fill grant at (63, 31) registers fill_done=1 together with that command. Next state is IDLE (fill_busy=0 the following cycle) with pointer (0, 0).
- A fill emits exactly 2048 commands.
- With the CPU saturating the port, at most MAX_STALL CPU commands are granted between consecutive fill commands.
- CPU buffer ops during FILL stall (cpu_ready=0) until IDLE, so the fill pattern is never interleaved with CPU buffer data.

Test Plan:
1. Reset, then release → start=0, in=0, clearx=0, cleary=0, fill_busy=0, fill_done=0, cpu_ready=1.
2. fill_req with mode 0, value 0x5A, CPU idle:
   - 2048 consecutive start pulses beginning 2 cycles after the fill_req cycle.
   - 1st pulse: in=0xFC005A at (0, 0); 64th at (63, 0); 65th at (0, 1); 2048th at (63, 31) with fill_done=1.
   - fill_busy=0 on the next cycle.
3. MAX_STALL=4, cpu_start held with opcode 13 during a mode-1 fill of 0x7:
   - Repeating grant pattern: 4 CPU commands, then 1 fill command with in=0xF40007.
   - cpu_ready=0 exactly on the forced-fill cycles.
   - Fill completes after 10240 cycles.
4. CPU command 0xFC0011 offered at fill start → cpu_ready=0 throughout FILL; accepted on the first IDLE cycle with clearx=0, cleary=0; pointer becomes (1, 0).
5. IDLE, three CPU 244 commands after 62 prior CPU 252 commands → clearx/cleary (62, 0), (63, 0), (0, 1).
6. Reset asserted after 100 fill commands → outputs 0 asynchronously, no fill_done. A new fill_req restarts at (0, 0). A fill_req pulsed mid-fill is ignored (count stays 2048).
